hex_scan_controller: RTL and testbench

//  Time-multiplexed scan controller for the 8-digit hex 7-segment display.

---
 rtl/hex_scan_controller_if.sv | 35 +++
 rtl/hex_scan_controller.sv | 174 +++++++++++++++++
 tb/tb_hex_scan_controller.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_scan_controller_if.sv
// -----------------------------------------------------------------------------
// hex_scan_controller_if
//   Load port of the 8-digit hex scan controller.
//
//   Handshake: a word transfers on every rising clk edge where load_valid and
//   load_ready are both 1. The requester holds load_valid and load_data stable
//   until that edge. load_ready may rise or fall at any time and does not
//   depend on load_valid. load_data is ignored whenever no transfer happens.
//
//   Signals
//     load_valid  requester -> controller  a word is offered on load_data
//     load_data   requester -> controller  32-bit display word, nibble 0 = rightmost digit
//     load_ready  controller -> requester  no word is pending, a new one can be taken
//
//   Modports
//     master  requester side
//     slave   controller side
// -----------------------------------------------------------------------------
interface hex_scan_controller_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/hex_scan_controller.sv
// -----------------------------------------------------------------------------
// hex_scan_controller
//   Time-multiplexed scan controller for an 8-digit hex 7-segment display.
//   A 32-bit display word is shown one nibble per digit slot. Digit k shows
//   word[4*k +: 4]. Each slot is REFRESH_DIV clock cycles long. The first GUARD
//   cycles of each slot keep every anode off, so the previous digit's segments
//   cannot ghost onto the next digit.
//
//   New words are taken through a one-deep pending register. They move into
//   the display register only at a frame boundary, which is the last cycle of
//   digit 7. As a result, no frame ever mixes two words.
//
//   Parameters
//     REFRESH_DIV  clk cycles per digit slot (must be >= GUARD+2)
//     GUARD        all-anodes-off cycles at the start of each slot (>= 1)
//
//   Ports
//     clk         system clock
//     rst_n       synchronous reset, active low
//     load        load handshake (slave side of hex_scan_controller_if)
//     blank_lz    1 = blank leading-zero digits
//     dp_mask     bit k lights the decimal point of digit k (used live)
//     digit_sel   digit currently scanned, 0..7
//     nibble_out  nibble of the display word for digit_sel
//     anode_n     active-low one-hot digit enables
//     seg_n       active-low segments {g,f,e,d,c,b,a}
//     dp_n        active-low decimal point
//     frame_done  1-cycle pulse on the first cycle of every new frame
// -----------------------------------------------------------------------------
module hex_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  hex_scan_controller_if.slave        load,
  input  logic                        blank_lz,
  input  logic [7:0]                  dp_mask,
  output logic [2:0]                  digit_sel,
  output logic [3:0]                  nibble_out,
  output logic [7:0]                  anode_n,
  output logic [6:0]                  seg_n,
  output logic                        dp_n,
  output logic                        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      disp;        // word currently being scanned out
  logic [31:0]      pend;        // word accepted but not yet displayed
  logic             pend_valid;
  logic [CNT_W-1:0] cnt;         // cycle position inside the current slot

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic       cnt_last;
  logic       frame_end;
  logic       load_fire;
  logic       in_guard;
  logic [2:0] top_idx;
  logic       lz_blank;
  logic       lit;

  assign cnt_last  = (cnt == CNT_LAST);
  assign frame_end = cnt_last && (digit_sel == 3'd7);

  // While a word is pending, load_ready is low. A pending word at the frame
  // boundary therefore never competes with a new load.
  assign load.load_ready = ~pend_valid;
  assign load_fire       = load.load_valid && ~pend_valid;

  // The guard phase is decoded straight from the registered counter, so the
  // outputs change in the same cycle as cnt without an extra pipeline stage.
  assign in_guard = (cnt < CNT_GUARD);

  // Position of the highest non-zero nibble. When disp is zero this is 0,
  // so digit 0 always stays visible and an all-zero word shows "0".
  always_comb begin
    top_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (disp[4*k +: 4] != 4'h0) begin
        top_idx = 3'(k);
      end
    end
  end

  // A leading-zero digit is dark for its whole slot, the same as a guard.
  assign lz_blank = blank_lz && (digit_sel > top_idx);
  assign lit      = ~in_guard && ~lz_blank;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      cnt        <= '0;
      digit_sel  <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;

      if (cnt_last) begin
        cnt       <= '0;
        digit_sel <= digit_sel + 3'd1;   // wraps 7 -> 0 naturally
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // The two branches are mutually exclusive because load_fire needs
      // pend_valid low. A load accepted on the boundary cycle lands in pend
      // and waits for the next boundary.
      if (frame_end && pend_valid) begin
        disp       <= pend;
        pend_valid <= 1'b0;
      end else if (load_fire) begin
        pend       <= load.load_data;
        pend_valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hex to segment decode, active-high {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;  // abcdef
      4'h1:    s = 7'h06;  // bc
      4'h2:    s = 7'h5B;  // abdeg
      4'h3:    s = 7'h4F;  // abcdg
      4'h4:    s = 7'h66;  // bcfg
      4'h5:    s = 7'h6D;  // acdfg
      4'h6:    s = 7'h7D;  // acdefg
      4'h7:    s = 7'h07;  // abc
      4'h8:    s = 7'h7F;  // abcdefg
      4'h9:    s = 7'h6F;  // abcdfg
      4'hA:    s = 7'h77;  // abcefg
      4'hB:    s = 7'h7C;  // cdefg
      4'hC:    s = 7'h39;  // adef
      4'hD:    s = 7'h5E;  // bcdeg
      4'hE:    s = 7'h79;  // adefg
      default: s = 7'h71;  // aefg (F)
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Display outputs
  // ---------------------------------------------------------------------------
  assign nibble_out = disp[{digit_sel, 2'b00} +: 4];

  always_comb begin
    anode_n = 8'hFF;
    seg_n   = 7'h7F;
    dp_n    = 1'b1;
    if (lit) begin
      anode_n = ~(8'b1 << digit_sel);
      seg_n   = ~hex_to_seg(nibble_out);
      dp_n    = ~dp_mask[digit_sel];
    end
  end

endmodule

// File: tb/tb_hex_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_controller
//   Bench for hex_scan_controller with REFRESH_DIV=4 and GUARD=1, so one
//   frame is 32 cycles.
//
//   The reference model treats time as a cycle index t. The slot position is
//   t % 4 and the digit is (t / 4) % 8. Accepted words wait in a queue and
//   are promoted at each frame boundary. Segment patterns come from the
//   letter lists in the hex table.
// -----------------------------------------------------------------------------
module tb_hex_scan_controller;
  localparam int DIV   = 4;
  localparam int GRD   = 1;
  localparam int FRAME = DIV * 8;

  // ---------------------------------------------------------------------------
  // Clock, reset and DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blank_lz = 1'b0;
  logic [7:0] dp_mask = 8'h00;
  logic [2:0] digit_sel;
  logic [3:0] nibble_out;
  logic [7:0] anode_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_done;

  hex_scan_controller_if lif ();

  always #5 clk = ~clk;

  hex_scan_controller #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lif),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .digit_sel  (digit_sel),
    .nibble_out (nibble_out),
    .anode_n    (anode_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  string seg_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_on(input logic [3:0] v);
    string      s;
    logic [6:0] p;
    int         idx;
    s = seg_str[v];
    p = 7'h00;
    for (int i = 0; i < s.len(); i++) begin
      idx = int'(s[i]) - 97;
      p[idx] = 1'b1;
    end
    return p;
  endfunction

  logic [31:0] exp_q[$];      // accepted words not yet on the display
  logic [31:0] m_disp = '0;
  int          m_t = 0;
  bit          m_fd = 1'b0;
  bit          m_known = 1'b0;

  always @(posedge clk) begin
    bit boundary;
    bit accept;
    if (!rst_n) begin
      m_known = 1'b1;
      m_t     = 0;
      m_disp  = '0;
      m_fd    = 1'b0;
      exp_q.delete();
    end else if (m_known) begin
      boundary = ((m_t % FRAME) == FRAME - 1);
      accept   = (lif.load_valid === 1'b1) && (exp_q.size() == 0);
      m_fd     = boundary;
      if (boundary && exp_q.size() > 0) m_disp = exp_q.pop_front();
      if (accept) exp_q.push_back(lif.load_data);
      m_t++;
    end
  end

  // Compare process: every cycle once the model is known.
  always @(negedge clk) begin
    int         cnt;
    int         dig;
    int         top;
    bit         dark;
    logic [3:0] nib;
    logic [7:0] an;
    logic [6:0] sg;
    logic       dp;
    if (m_known) begin
      cnt = m_t % DIV;
      dig = (m_t / DIV) % 8;
      top = 0;
      for (int k = 0; k < 8; k++) begin
        if (((m_disp >> (4 * k)) & 32'hF) != 0) top = k;
      end
      nib  = 4'((m_disp >> (4 * dig)) & 32'hF);
      dark = (cnt < GRD) || (blank_lz && (dig > top));
      an   = dark ? 8'hFF : ~(8'h01 << dig);
      sg   = dark ? 7'h7F : ~seg_on(nib);
      dp   = dark ? 1'b1 : ~dp_mask[dig];
      check("m_digit_sel",  32'(digit_sel),      32'(dig));
      check("m_nibble",     32'(nibble_out),     32'(nib));
      check("m_anode",      32'(anode_n),        32'(an));
      check("m_seg",        32'(seg_n),          32'(sg));
      check("m_dp",         32'(dp_n),           32'(dp));
      check("m_load_ready", 32'(lif.load_ready), 32'(exp_q.size() == 0));
      check("m_frame_done", 32'(frame_done),     32'(m_fd));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [31:0] d);
    bit r;
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      r = lif.load_ready;
      @(posedge clk);
      if (r) done = 1'b1;
    end
    #1;
    lif.load_valid = 1'b0;
    lif.load_data  = $urandom;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL load_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
  endtask

  // Returns at the negedge of the first cycle of the next frame.
  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got no frame_done expected one within 80 cycles");
    end
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [6:0] scan_lit [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

  initial begin
    logic [7:0]  an;
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] w;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;

    // Reset: one guard cycle, then digit 0 shows "0".
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_guard_anode", 32'(anode_n), 32'hFF);
    check("rst_guard_dp", 32'(dp_n), 32'h1);
    @(negedge clk);
    check("rst_anode", 32'(anode_n), 32'hFE);
    check("rst_seg", 32'(seg_n), 32'h40);
    check("rst_ready", 32'(lif.load_ready), 32'h1);
    check("rst_fd", 32'(frame_done), 32'h0);

    // Scan: digit k shows k+1.
    do_load(32'h8765_4321);
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < DIV; c++) begin
        an = ~(8'h01 << k);
        if (c >= GRD) begin
          check("scan_seg", 32'(seg_n), 32'(scan_lit[k]));
          check("scan_anode", 32'(anode_n), 32'(an));
        end else begin
          check("scan_guard", 32'(anode_n), 32'hFF);
        end
        @(negedge clk);
      end
    end
    check("scan_fd", 32'(frame_done), 32'h1);

    // Handshake: B stalls until A reaches the display.
    wa = 32'hA5C3_1E97;
    wb = 32'h0F0F_2468;
    do_load(wa);
    @(negedge clk);
    check("hs_stall_ready", 32'(lif.load_ready), 32'h0);
    do_load(wb);
    @(negedge clk);
    check("hs_a_shown", 32'(nibble_out), 32'h7);
    check("hs_b_pending", 32'(lif.load_ready), 32'h0);
    wait_frame();
    check("hs_b_shown", 32'(nibble_out), 32'h8);

    // Boundary race: accept on the very last cycle of the frame.
    wait_frame();
    repeat (FRAME - 1) @(posedge clk);
    #1;
    lif.load_valid = 1'b1;
    lif.load_data  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 lif.load_valid = 1'b0;
    @(negedge clk);
    check("race_fd", 32'(frame_done), 32'h1);
    check("race_old_word", 32'(nibble_out), 32'h8);
    check("race_pending", 32'(lif.load_ready), 32'h0);
    wait_frame();
    for (int c = 1; c < DIV; c++) begin
      @(negedge clk);
      check("race_seg_F", 32'(seg_n), 32'h0E);
    end

    // Leading-zero blanking.
    blank_lz = 1'b1;
    dp_mask  = 8'hFF;
    do_load(32'h0000_00A0);
    wait_frame();
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < DIV; c++) begin
        an = ~(8'h01 << k);
        if (k <= 1 && c >= GRD) begin
          check("blank_anode", 32'(anode_n), 32'(an));
          check("blank_seg", 32'(seg_n), (k == 0) ? 32'h40 : 32'h08);
          check("blank_dp", 32'(dp_n), 32'h0);
        end else begin
          check("blank_dark", 32'(anode_n), 32'hFF);
          check("blank_dark_dp", 32'(dp_n), 32'h1);
        end
        @(negedge clk);
      end
    end
    do_load(32'h0000_0000);
    wait_frame();
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < DIV; c++) begin
        if (k == 0 && c >= GRD) begin
          check("zero_seg", 32'(seg_n), 32'h40);
        end else begin
          check("zero_dark", 32'(anode_n), 32'hFF);
        end
        @(negedge clk);
      end
    end
    blank_lz = 1'b0;
    dp_mask  = 8'h00;

    // Reset mid-frame with a pending word.
    do_load(32'h1234_5678);
    do_load(32'h9ABC_DEF0);
    pulse_reset(2);
    @(negedge clk);
    check("rst6_ready", 32'(lif.load_ready), 32'h1);
    check("rst6_nibble", 32'(nibble_out), 32'h0);
    wait_frame();
    wait_frame();
    check("rst6_discard", 32'(nibble_out), 32'h0);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      w = $urandom;
      w = w >> (4 * $urandom_range(0, 7));
      blank_lz = 1'($urandom_range(0, 1));
      dp_mask  = 8'($urandom);
      do_load(w);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      if ($urandom_range(0, 9) == 0) pulse_reset($urandom_range(1, 3));
    end
    repeat (2 * FRAME) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2000000");
    $fatal(1, "watchdog");
  end

endmodule
